mem_data_arbiter: RTL

Two-port round-robin arbiter sharing the single-port data memory (8-bit address, 32-bit signed data) between the processor's load/store port (port 0) and a secondary master (port 1, e.g. program loader or debug access). Each request is handshaken with a one-cycle ack and registered read data. The block sits between the masters and `mem_data`, driving its write-enable, address and write-data pins.

---
 rtl/mem_data_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory.
// Port 0 is the load/store port and port 1 is a secondary master.
// Each grant takes an IDLE cycle, where the memory is driven, followed by
// an ACK cycle, where the one-cycle ack is returned.
module mem_data_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic [ADDR_W-1:0] sel_addr_q;

    logic any_req;
    logic win1;

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        any_req = p0_req | p1_req;
        win1    = p1_req & (~p0_req | ~last_q);
    end

    // Memory pins: winner's access in IDLE, held address and no write in ACK.
    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                if (any_req) begin
                    if (win1) begin
                        mem_wr    = p1_wr;
                        mem_addr  = p1_addr;
                        mem_wdata = p1_wdata;
                    end else begin
                        mem_wr    = p0_wr;
                        mem_addr  = p0_addr;
                        mem_wdata = p0_wdata;
                    end
                end
            end else begin
                mem_addr = sel_addr_q;
            end
        end
    end

    // Grant FSM with registered acks, read data and saturating grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            sel_addr_q <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= ACK;
                        last_q     <= win1;
                        sel_addr_q <= win1 ? p1_addr : p0_addr;
                        if (win1) begin
                            p1_ack <= 1'b1;
                            if (!p1_wr) begin
                                p1_rdata <= mem_rdata;
                            end
                            if (gnt_cnt1 != {CNT_W{1'b1}}) begin
                                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
                            end
                        end else begin
                            p0_ack <= 1'b1;
                            if (!p0_wr) begin
                                p0_rdata <= mem_rdata;
                            end
                            if (gnt_cnt0 != {CNT_W{1'b1}}) begin
                                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
                            end
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
